// File: rtl/shifter_pipe_if.sv
// shifter_pipe_if: handshake and data bundle for the pipelined barrel shifter.
//   in_valid/in_ready   : input beat handshake
//   in_a, in_op, in_imm,
//   in_amt, in_carry    : operand, operation, encoding mode, amount, C flag
//   out_valid/out_ready : result beat handshake
//   out_data, out_carry : shifted result and shifter carry-out
// master = producer/consumer side (execute stage), slave = shifter side.
interface shifter_pipe_if #(
  parameter int WIDTH = 32,
  parameter int AMT_W = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_a;
  logic [2:0]       in_op;
  logic             in_imm;
  logic [AMT_W-1:0] in_amt;
  logic             in_carry;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic             out_carry;

  modport master (
    output in_valid, in_a, in_op, in_imm, in_amt, in_carry, out_ready,
    input  in_ready, out_valid, out_data, out_carry
  );

  modport slave (
    input  in_valid, in_a, in_op, in_imm, in_amt, in_carry, out_ready,
    output in_ready, out_valid, out_data, out_carry
  );
endinterface

// File: rtl/shifter_pipe.sv
// shifter_pipe: pipelined ARM barrel shifter (operand-2 path).
//   clk     : clock, rising edge
//   reset_n : synchronous active-low reset (clears stage valids only)
//   bus     : shifter_pipe_if slave (input beat, result beat, handshakes)
// The shift result is formed combinationally from the accepted beat and
// then carried through LATENCY register stages, each with its own valid.
module shifter_pipe #(
  parameter int WIDTH   = 32,
  parameter int AMT_W   = 8,
  parameter int LATENCY = 2
) (
  input  logic          clk,
  input  logic          reset_n,
  shifter_pipe_if.slave bus
);
  localparam int LW = $clog2(WIDTH);
  localparam int SW = LATENCY * (WIDTH + 1);

  typedef enum logic [2:0] {
    OP_LSL = 3'd0,
    OP_LSR = 3'd1,
    OP_ASR = 3'd2,
    OP_ROR = 3'd3,
    OP_RRX = 3'd4
  } op_e;

  // ---------------- effective amount / RRX selection ----------------
  logic [LW-1:0]    w_amt_lo;
  logic [AMT_W-1:0] w_n;
  logic             w_rrx;

  always_comb begin
    w_amt_lo = bus.in_amt[LW-1:0];
    w_rrx    = (bus.in_op == OP_RRX);
    w_n      = bus.in_amt;
    if (bus.in_imm) begin
      w_n = AMT_W'(w_amt_lo);
      // Immediate #0 encodes #WIDTH for LSR/ASR and RRX for ROR.
      if (w_amt_lo == '0) begin
        if (bus.in_op == OP_LSR || bus.in_op == OP_ASR) w_n = AMT_W'(WIDTH);
        if (bus.in_op == OP_ROR) w_rrx = 1'b1;
      end
    end
  end

  // ---------------- shift products ----------------
  // One guard bit on the far side of each shift captures the last bit
  // shifted out, which is exactly the ARM carry for every n >= 1
  // (including n == WIDTH and n > WIDTH, where it falls off to 0 / sign).
  logic [WIDTH:0]   w_lsl;
  logic [WIDTH:0]   w_lsr;
  logic [WIDTH:0]   w_asr;
  logic [LW-1:0]    w_r;
  logic [LW-1:0]    w_rl;
  logic [WIDTH-1:0] w_ror;

  assign w_lsl = {1'b0, bus.in_a} << w_n;
  assign w_lsr = {bus.in_a, 1'b0} >> w_n;
  assign w_asr = $signed({bus.in_a, 1'b0}) >>> w_n;
  assign w_r   = w_n[LW-1:0];
  // Left amount is (WIDTH - r) mod WIDTH; r == 0 gives a | a == a.
  assign w_rl  = '0 - w_r;
  assign w_ror = (bus.in_a >> w_r) | (bus.in_a << w_rl);

  logic [WIDTH-1:0] w_res;
  logic             w_c;

  always_comb begin
    w_res = bus.in_a;
    w_c   = bus.in_carry;
    if (w_rrx) begin
      w_res = {bus.in_carry, bus.in_a[WIDTH-1:1]};
      w_c   = bus.in_a[0];
    end else if (w_n != '0) begin
      case (bus.in_op)
        OP_LSL:  {w_c, w_res} = w_lsl;
        OP_LSR:  {w_res, w_c} = w_lsr;
        OP_ASR:  {w_res, w_c} = w_asr;
        OP_ROR: begin
          w_res = w_ror;
          w_c   = w_ror[WIDTH-1];
        end
        default: ;
      endcase
    end
  end

  // ---------------- pipeline ----------------
  logic [LATENCY-1:0]            r_vld;
  logic [LATENCY-1:0][WIDTH:0]   r_stage;
  logic [LATENCY-1:0]            w_load;
  logic [LATENCY-1:0]            w_src_vld;
  logic [LATENCY-1:0][WIDTH:0]   w_src;

  // A stage may load when it or any stage after it is empty, or the output
  // is being consumed: this is the recursive "empty or next advances" rule
  // unrolled so that no combinational loop through w_load is formed.
  always_comb begin
    w_load = '0;
    for (int unsigned k = 0; k < LATENCY; k++) begin
      w_load[k] = bus.out_ready;
      for (int unsigned j = k; j < LATENCY; j++) begin
        if (!r_vld[j]) w_load[k] = 1'b1;
      end
    end
  end

  // Stage k's source is stage k-1, or the shifter result for stage 0.
  assign w_src_vld = LATENCY'({r_vld, bus.in_valid});
  assign w_src     = SW'({r_stage, w_c, w_res});

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_vld <= '0;
    end else begin
      for (int unsigned k = 0; k < LATENCY; k++) begin
        if (w_load[k]) r_vld[k] <= w_src_vld[k];
      end
    end
  end

  always_ff @(posedge clk) begin
    for (int unsigned k = 0; k < LATENCY; k++) begin
      if (w_load[k] && w_src_vld[k]) r_stage[k] <= w_src[k];
    end
  end

  assign bus.in_ready  = w_load[0];
  assign bus.out_valid = r_vld[LATENCY-1];
  assign {bus.out_carry, bus.out_data} = r_stage[LATENCY-1];
endmodule

// File: tb/tb_shifter_pipe.sv
module tb_shifter_pipe;
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  shifter_pipe_if #(.WIDTH(32), .AMT_W(8)) bus ();

  shifter_pipe #(.WIDTH(32), .AMT_W(8), .LATENCY(2)) dut (
    .clk(clk),
    .reset_n(reset_n),
    .bus(bus)
  );

  int checks = 0;
  int failures = 0;
  logic [32:0] sb[$];
  int cyc = 0;
  int first_acc = -1;
  int first_out = -1;
  bit rnd_bp = 0;
  bit prev_hold = 0;
  logic [32:0] prev_out;
  logic [32:0] mon_exp;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Reference model written directly from the ARM shift rules.
  function automatic logic [32:0] model(input logic [31:0] a, input logic [2:0] op,
                                        input logic imm, input logic [7:0] amt,
                                        input logic cin);
    int n;
    int r;
    bit rrx;
    logic [31:0] d;
    if (op >= 3'd5) return {cin, a};
    rrx = (op == 3'd4);
    if (imm) begin
      n = int'(amt[4:0]);
      if (n == 0 && (op == 3'd1 || op == 3'd2)) n = 32;
      if (n == 0 && op == 3'd3) rrx = 1;
    end else begin
      n = int'(amt);
    end
    if (rrx) return {a[0], cin, a[31:1]};
    if (n == 0) return {cin, a};
    case (op)
      3'd0: begin
        if (n < 32) begin d = a << n; return {a[32-n], d}; end
        else if (n == 32) return {a[0], 32'h0};
        else return 33'h0;
      end
      3'd1: begin
        if (n < 32) begin d = a >> n; return {a[n-1], d}; end
        else if (n == 32) return {a[31], 32'h0};
        else return 33'h0;
      end
      3'd2: begin
        if (n < 32) begin d = $signed(a) >>> n; return {a[n-1], d}; end
        else return {a[31], {32{a[31]}}};
      end
      default: begin
        r = n % 32;
        if (r != 0) begin d = (a >> r) | (a << (32 - r)); return {a[r-1], d}; end
        else return {a[31], a};
      end
    endcase
  endfunction

  always @(posedge clk) cyc++;

  always @(posedge clk) begin
    #1;
    if (rnd_bp) bus.out_ready = 1'($urandom_range(0, 1));
  end

  // Monitor: pops the scoreboard on every delivered beat, checks stalls.
  always @(negedge clk) begin
    if (!reset_n) begin
      prev_hold = 0;
    end else begin
      if (prev_hold)
        chk("stall_stable", {31'h0, bus.out_valid, bus.out_carry, bus.out_data}, {31'h0, 1'b1, prev_out});
      if (bus.out_valid && first_out < 0) first_out = cyc;
      if (bus.out_valid && bus.out_ready) begin
        if (sb.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_beat actual=%0h required=none", {bus.out_carry, bus.out_data});
        end else begin
          mon_exp = sb.pop_front();
          chk("result", {31'h0, bus.out_carry, bus.out_data}, {31'h0, mon_exp});
        end
      end
      prev_hold = bus.out_valid && !bus.out_ready;
      prev_out  = {bus.out_carry, bus.out_data};
    end
  end

  task automatic send(input logic [31:0] a, input logic [2:0] op, input logic imm,
                      input logic [7:0] amt, input logic cin, input logic [32:0] exp,
                      output int waits);
    bit acc;
    @(posedge clk);
    #1;
    bus.in_a = a; bus.in_op = op; bus.in_imm = imm; bus.in_amt = amt;
    bus.in_carry = cin; bus.in_valid = 1'b1;
    waits = 0;
    acc = 0;
    while (!acc && waits <= 200) begin
      @(negedge clk);
      if (bus.in_ready) acc = 1;
      else waits++;
    end
    if (acc) begin
      sb.push_back(exp);
      if (first_acc < 0) first_acc = cyc;
    end else begin
      checks++;
      failures++;
      $display("FAIL accept_timeout actual=%0d required=<=200", waits);
    end
  endtask

  task automatic idle();
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic drain(input string name);
    int t;
    t = 0;
    while (sb.size() != 0 && t < 500) begin
      @(negedge clk);
      t++;
    end
    @(negedge clk);
    chk(name, 64'(sb.size()), 64'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

  initial begin
    int w;
    int tw;
    logic [31:0] ra;
    logic [2:0]  rop;
    logic        rimm;
    logic [7:0]  ramt;
    logic        rc;

    bus.in_valid = 1'b0; bus.in_a = '0; bus.in_op = '0; bus.in_imm = 1'b0;
    bus.in_amt = '0; bus.in_carry = 1'b0; bus.out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 reset_n = 1'b1;
    @(negedge clk);
    chk("reset_out_valid", 64'(bus.out_valid), 64'd0);
    chk("reset_in_ready", 64'(bus.in_ready), 64'd1);

    // Reset with full pipeline: in-flight beats must vanish.
    @(posedge clk);
    #1 bus.out_ready = 1'b0;
    send(32'h1, 3'd0, 1'b0, 8'd1, 1'b0, 33'h0_0000_0002, w);
    send(32'h2, 3'd0, 1'b0, 8'd1, 1'b0, 33'h0_0000_0004, w);
    idle();
    @(negedge clk);
    chk("full_in_ready", 64'(bus.in_ready), 64'd0);
    chk("full_out_valid", 64'(bus.out_valid), 64'd1);
    @(posedge clk);
    #1 reset_n = 1'b0;
    sb.delete();
    @(posedge clk);
    #1 reset_n = 1'b1;
    @(negedge clk);
    chk("rst_mid_out_valid", 64'(bus.out_valid), 64'd0);
    chk("rst_mid_in_ready", 64'(bus.in_ready), 64'd1);
    @(posedge clk);
    #1 bus.out_ready = 1'b1;
    repeat (4) @(negedge clk);

    // Register-mode boundaries, a=0x8000_0001, C=0.
    send(32'h8000_0001, 3'd0, 1'b0, 8'd0,  1'b0, {1'b0, 32'h8000_0001}, w);
    send(32'h8000_0001, 3'd0, 1'b0, 8'd1,  1'b0, {1'b1, 32'h0000_0002}, w);
    send(32'h8000_0001, 3'd0, 1'b0, 8'd32, 1'b0, {1'b1, 32'h0000_0000}, w);
    send(32'h8000_0001, 3'd0, 1'b0, 8'd33, 1'b0, {1'b0, 32'h0000_0000}, w);
    send(32'h8000_0001, 3'd1, 1'b0, 8'd32, 1'b0, {1'b1, 32'h0000_0000}, w);
    send(32'h8000_0001, 3'd2, 1'b0, 8'd40, 1'b0, {1'b1, 32'hFFFF_FFFF}, w);
    send(32'h8000_0001, 3'd3, 1'b0, 8'd32, 1'b0, {1'b1, 32'h8000_0001}, w);
    send(32'h8000_0001, 3'd3, 1'b0, 8'd36, 1'b0, {1'b0, 32'h1800_0000}, w);
    // Immediate remap, C=1; amt upper bits set to show they are ignored.
    send(32'h8000_0001, 3'd1, 1'b1, 8'h20, 1'b1, {1'b1, 32'h0000_0000}, w);
    send(32'h8000_0001, 3'd2, 1'b1, 8'h00, 1'b1, {1'b1, 32'hFFFF_FFFF}, w);
    send(32'h8000_0001, 3'd3, 1'b1, 8'h00, 1'b1, {1'b1, 32'hC000_0000}, w);
    send(32'h8000_0001, 3'd0, 1'b1, 8'hE0, 1'b1, {1'b1, 32'h8000_0001}, w);
    send(32'h8000_0001, 3'd1, 1'b1, 8'h24, 1'b1, {1'b0, 32'h0800_0000}, w);
    // Explicit RRX and pass-through.
    send(32'h0000_0003, 3'd4, 1'b0, 8'd9,  1'b0, {1'b1, 32'h0000_0001}, w);
    send(32'h1234_5678, 3'd6, 1'b0, 8'd7,  1'b1, {1'b1, 32'h1234_5678}, w);
    idle();
    drain("directed_drained");

    // Back-to-back streaming of 16 beats.
    first_acc = -1;
    first_out = -1;
    tw = 0;
    for (int i = 0; i < 16; i++) begin
      send(32'h1, 3'd0, 1'b0, 8'(i), 1'b0, {1'b0, 32'h1 << i}, w);
      tw += w;
    end
    idle();
    drain("stream_drained");
    chk("stream_latency", 64'(first_out - first_acc), 64'd2);
    chk("stream_no_stall", 64'(tw), 64'd0);

    // Random beats with random backpressure and input gaps.
    rnd_bp = 1;
    for (int i = 0; i < 1000; i++) begin
      if ($urandom_range(0, 3) == 0) idle();
      ra   = $urandom;
      rop  = 3'($urandom_range(0, 7));
      rimm = 1'($urandom_range(0, 1));
      rc   = 1'($urandom_range(0, 1));
      case ($urandom_range(0, 2))
        0: ramt = 8'($urandom_range(0, 40));
        1: ramt = 8'($urandom_range(0, 255));
        default: ramt = {3'($urandom_range(0, 7)), 5'd0};
      endcase
      send(ra, rop, rimm, ramt, rc, model(ra, rop, rimm, ramt, rc), w);
    end
    rnd_bp = 0;
    idle();
    @(posedge clk);
    #2 bus.out_ready = 1'b1;
    drain("random_drained");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/shifter_pipe.md
# shifter_pipe

Parametrised, pipelined ARM barrel shifter for the operand-2 path of the execute stage. It replaces the single-cycle 32-bit combinational shifter and adds three things that shifter lacks: configurable width and latency, full ARM carry-out semantics for both immediate-encoded and register-specified shift amounts, and a valid/ready handshake so the execute pipeline can stall it.

## Interface
Parameters:
- WIDTH, 32: datapath width; power of two, at least 8. LW = log2(WIDTH).
- AMT_W, 8: width of the shift-amount input; at least LW+1.
- LATENCY, 2: number of register stages, at least 1.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset_n  in  1  reset, synchronous and active-low.
- in_valid  in  1  input beat present.
- in_ready  out  1  block accepts the beat this cycle.
- in_a  in  WIDTH  operand to shift.
- in_op  in  3  operation: 0 LSL, 1 LSR, 2 ASR, 3 ROR, 4 RRX; 5–7 pass-through.
- in_imm  in  1  1: immediate encoding, using in_amt[LW-1:0] only; 0: register amount, using all of in_amt.
- in_amt  in  AMT_W  shift amount.
- in_carry  in  1  current C flag.
- out_valid  out  1  result beat present.
- out_ready  in  1  consumer accepts the result.
- out_data  out  WIDTH  shifted result.
- out_carry  out  1  shifter carry-out.

## Operation
Effective amount n:
- Register mode: n = in_amt.
- Immediate mode: n = in_amt[LW-1:0], with ARM zero remapping:
  - LSL #0 → n = 0.
  - LSR #0 → n = WIDTH.
  - ASR #0 → n = WIDTH.
  - ROR #0 → RRX.

Result and carry:
- n = 0, for LSL/LSR/ASR/ROR: data = a, carry = in_carry.
- LSL:
  - 1 ≤ n < W: a << n, carry = a[W-n].
  - n = W: 0, carry = a[0].
  - n > W: 0, carry = 0.
- LSR:
  - 1 ≤ n < W: a >> n, carry = a[n-1].
  - n = W: 0, carry = a[W-1].
  - n > W: 0, carry = 0.
- ASR:
  - 1 ≤ n < W: arithmetic shift, carry = a[n-1].
  - n ≥ W: all bits = a[W-1], carry = a[W-1].
- ROR, with r = n mod W:
  - r ≠ 0: rotate right by r, carry = a[r-1].
  - r = 0, n ≠ 0: data = a, carry = a[W-1].
- RRX: {in_carry, a[W-1:1]}, carry = a[0]; in_amt ignored.
- op 5–7: data = a, carry = in_carry.

Pipeline:
- The result is computed combinationally from the accepted beat, then carried through LATENCY registers, each with its own valid bit.
- Stage k loads when it is empty or stage k+1 (or the output, for the last stage) advances in the same cycle.
- in_ready = first stage loads. This path is combinational from out_ready.
- No beat is ever dropped, duplicated or reordered.
- Data and carry registers are reset-free; only the valid bits are reset.

## Timing
- Reset (reset_n = 0 at a rising edge):
  - All stage valids clear, so out_valid = 0 next cycle.
  - in_ready = 1 from the cycle after reset is released.
  - out_data and out_carry are don't-care while out_valid = 0; the bench must not check them.
- Reset mid-operation discards every in-flight beat. No output is produced for those beats.
- Latency: a beat accepted at edge t appears with out_valid = 1 after edge t+LATENCY-1, i.e. it is visible in cycle t+LATENCY, provided there is no stall.
- Throughput: one beat per cycle while out_ready = 1.
- Stall (out_valid = 1, out_ready = 0):
  - out_data and out_carry hold stable.
  - The pipeline compresses bubbles.
  - in_ready drops only when all LATENCY stages are full.
- Simultaneous pop and push on a full pipeline: both occur in the same cycle, and in_ready = 1.
- Inputs are sampled only on cycles where in_valid & in_ready = 1.

## Test plan
All cases use WIDTH=32, AMT_W=8, LATENCY=2.
1. Reset with pipeline full: issue 2 beats, hold out_ready=0, assert reset_n=0 for one cycle → out_valid=0 next cycle; in_ready=1 the cycle after release; no stale beat ever appears.
2. Register-mode boundaries, a=0x8000_0001, carry=0:
   - LSL 0 → 0x8000_0001, C=0.
   - LSL 1 → 0x0000_0002, C=1.
   - LSL 32 → 0, C=1.
   - LSL 33 → 0, C=0.
   - LSR 32 → 0, C=1.
   - ASR 40 → 0xFFFF_FFFF, C=1.
   - ROR 32 → 0x8000_0001, C=1.
   - ROR 36 → 0x1800_0000, C=0.
3. Immediate remap, a=0x8000_0001, carry=1:
   - LSR #0 → 0, C=1.
   - ASR #0 → 0xFFFF_FFFF, C=1.
   - ROR #0 → RRX → 0xC000_0000, C=1.
   - LSL #0 → a, C=1.
4. Back-to-back streaming: 16 beats with in_valid=1 and out_ready=1 → first out_valid 2 cycles after the first accept; 16 consecutive results in order; in_ready never drops.
5. Random backpressure: 1000 random beats, with random out_ready and in_valid → results match the reference model in order; out_data and out_carry are stable whenever out_valid=1 and out_ready=0.
6. Pass-through: op=6, a=0x1234_5678, carry=1, amt=7 → 0x1234_5678, C=1.
